// File: rtl/ramp_adc_seq.sv
// Single-slope ramp ADC sequencer: discharge, ramp-count until comparator trip or timeout, hold result.
// Optional RAMP_ADC_AVG4_EN: four conversions per start, result is the floor of their mean.
module ramp_adc_seq #(
  parameter int CNT_W         = 12,
  parameter int DISCHARGE_CYC = 64,
  parameter int MAX_CNT       = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             comp_in,
  output logic             ramp_dis,
  output logic             busy,
  output logic [CNT_W-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrange
);

  localparam int DIS_W = (DISCHARGE_CYC > 2) ? $clog2(DISCHARGE_CYC) : 1;
  localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISCHARGE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    RAMP      = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t             state_r;
  logic               comp_meta_r;
  logic               comp_s_r;
  logic [DIS_W-1:0]   dis_cnt_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ramp_dis_r;
  logic               busy_r;
  logic [CNT_W-1:0]   sample_r;
  logic               sample_valid_r;
  logic               overrange_r;
  logic               capture_s;
  logic [CNT_W-1:0]   cap_val_s;
  logic               cap_ovr_s;

`ifdef RAMP_ADC_AVG4_EN
  logic [CNT_W+1:0]   acc_r;
  logic [1:0]         conv_idx_r;
  logic               ovr_acc_r;
  logic [CNT_W+1:0]   acc_sum_s;

  // Running sum including the conversion captured this cycle
  always_comb begin
    acc_sum_s = acc_r + {2'b00, cap_val_s};
  end
`endif

  // Ramp end detection; a comparator trip wins over a simultaneous timeout
  always_comb begin
    capture_s = 1'b0;
    cap_val_s = cnt_r;
    cap_ovr_s = 1'b0;
    if (state_r == RAMP) begin
      if (comp_s_r) begin
        capture_s = 1'b1;
        cap_val_s = cnt_r;
        cap_ovr_s = 1'b0;
      end else if (cnt_r == CNT_MAX) begin
        capture_s = 1'b1;
        cap_val_s = CNT_MAX;
        cap_ovr_s = 1'b1;
      end else begin
        capture_s = 1'b0;
      end
    end else begin
      capture_s = 1'b0;
    end
  end

  // Synchronizer, sequencer FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      comp_meta_r    <= 1'b0;
      comp_s_r       <= 1'b0;
      dis_cnt_r      <= {DIS_W{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      ramp_dis_r     <= 1'b1;
      busy_r         <= 1'b0;
      sample_r       <= {CNT_W{1'b0}};
      sample_valid_r <= 1'b0;
      overrange_r    <= 1'b0;
`ifdef RAMP_ADC_AVG4_EN
      acc_r          <= {(CNT_W+2){1'b0}};
      conv_idx_r     <= 2'd0;
      ovr_acc_r      <= 1'b0;
`endif
    end else begin
      comp_meta_r <= comp_in;
      comp_s_r    <= comp_meta_r;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= DISCHARGE;
            dis_cnt_r  <= {DIS_W{1'b0}};
            busy_r     <= 1'b1;
            ramp_dis_r <= 1'b1;
`ifdef RAMP_ADC_AVG4_EN
            acc_r      <= {(CNT_W+2){1'b0}};
            conv_idx_r <= 2'd0;
            ovr_acc_r  <= 1'b0;
`endif
          end
        end
        DISCHARGE: begin
          if (dis_cnt_r == DIS_LAST) begin
            state_r    <= RAMP;
            cnt_r      <= {CNT_W{1'b0}};
            ramp_dis_r <= 1'b0;
          end else begin
            dis_cnt_r <= dis_cnt_r + {{(DIS_W-1){1'b0}}, 1'b1};
          end
        end
        RAMP: begin
          if (capture_s) begin
            ramp_dis_r <= 1'b1;
`ifdef RAMP_ADC_AVG4_EN
            if (conv_idx_r == 2'd3) begin
              state_r        <= HOLD;
              sample_r       <= acc_sum_s[CNT_W+1:2];
              overrange_r    <= ovr_acc_r | cap_ovr_s;
              sample_valid_r <= 1'b1;
            end else begin
              acc_r      <= acc_sum_s;
              ovr_acc_r  <= ovr_acc_r | cap_ovr_s;
              conv_idx_r <= conv_idx_r + 2'd1;
              state_r    <= DISCHARGE;
              dis_cnt_r  <= {DIS_W{1'b0}};
            end
`else
            state_r        <= HOLD;
            sample_r       <= cap_val_s;
            overrange_r    <= cap_ovr_s;
            sample_valid_r <= 1'b1;
`endif
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        HOLD: begin
          if (sample_ready) begin
            state_r        <= IDLE;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          ramp_dis_r     <= 1'b1;
          busy_r         <= 1'b0;
          sample_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ramp_dis     = ramp_dis_r;
  assign busy         = busy_r;
  assign sample       = sample_r;
  assign sample_valid = sample_valid_r;
  assign overrange    = overrange_r;

endmodule
